// File: rtl/lsu_pkg.sv
// lsu_pkg: shared load codes, access-unit states, store mask constants and the alignment rule.
package lsu_pkg;
    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } load_ctrl_e;
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} dmem_state_e;
    localparam logic [3:0] MASK_LO_H = 4'b0011;
    localparam logic [3:0] MASK_HI_H = 4'b1100;
    localparam logic [3:0] MASK_WORD = 4'b1111;
    // Single-byte stores and byte loads can never be misaligned.
    function automatic logic misaligned(input logic we, input logic [2:0] ctrl, input logic [3:0] mask, input logic [1:0] a);
        if (we)
            return ((mask == MASK_LO_H || mask == MASK_HI_H) && a[0]) || (mask == MASK_WORD && a != 2'b00);
        return (ctrl == LD_H || ctrl == LD_HU) ? a[0] : (ctrl == LD_B || ctrl == LD_BU) ? 1'b0 : a != 2'b00;
    endfunction
endpackage

// File: rtl/load_aligner.sv
// load_aligner: shifts the read word to the addressed lane and sign/zero-extends it.
module load_aligner
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_ctrl,
    output logic [31:0] load_data
);
    logic [31:0] word;
    always_comb begin
        word = rdata >> {offset, 3'b000};
        load_data = load_ctrl == LD_B  ? {{24{word[7]}}, word[7:0]} :
                    load_ctrl == LD_BU ? {24'h0, word[7:0]} :
                    load_ctrl == LD_H  ? {{16{word[15]}}, word[15:0]} :
                    load_ctrl == LD_HU ? {16'h0, word[15:0]} : word;
    end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: runs one data-memory transaction at a time over req/ack,
// stalling upstream, with misalignment rejection and bus timeout.
module dmem_access_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    input  logic [2:0]  req_load_ctrl,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    localparam bit TO_EN = TIMEOUT_CYCLES != 0;
    dmem_state_e state, state_n;
    logic [CW-1:0] cnt;
    logic          we_q, misalign_q, bus_err_q;
    logic [2:0]    ctrl_q;
    logic [1:0]    off_q;
    logic [31:0]   rdata_q;
    logic          accept, bad, timeout;
    load_aligner u_align (.rdata(rdata_q), .offset(off_q), .load_ctrl(ctrl_q), .load_data(load_data));
    // The request presented during a misalign/bus_err pulse is the one just retired, so it is not re-accepted.
    always_comb begin
        bad = misaligned(req_we, req_load_ctrl, req_mask, req_addr[1:0]);
        accept = state == S_IDLE && req_valid && !misalign_q && !bus_err_q;
        timeout = TO_EN && state == S_BUS && !bus_ack && cnt + 1'b1 == TMAX;
        state_n = (state == S_RESP || timeout) ? S_IDLE :
                  (state == S_BUS && bus_ack) ? S_RESP :
                  (accept && !bad) ? S_BUS : state;
        stall = state == S_BUS || accept;
        bus_req = state == S_BUS;
        bus_we = bus_req && we_q;
        load_valid = state == S_RESP && !we_q;
        misalign = misalign_q;
        bus_err = bus_err_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt <= '0;
            we_q <= 1'b0;
            ctrl_q <= '0;
            off_q <= '0;
            rdata_q <= '0;
            misalign_q <= 1'b0;
            bus_err_q <= 1'b0;
            bus_addr <= '0;
            bus_wdata <= '0;
            bus_be <= '0;
        end else begin
            state <= state_n;
            misalign_q <= accept && bad;
            bus_err_q <= timeout;
            cnt <= state == S_BUS ? cnt + 1'b1 : '0;
            if (accept && !bad) begin
                we_q <= req_we;
                ctrl_q <= req_load_ctrl;
                off_q <= req_addr[1:0];
                bus_addr <= {req_addr[31:2], 2'b00};
                bus_wdata <= req_wdata;
                bus_be <= req_we ? req_mask : MASK_WORD;
            end
            if (state == S_BUS && bus_ack)
                rdata_q <= bus_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and randomized transactions checked against a size/offset reference model.
module tb_dmem_access_unit;
    localparam int TO = 4;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_mask = 0;
    logic [2:0]  req_load_ctrl = 0;
    logic        stall, load_valid, misalign, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 0;
    logic [31:0] bus_rdata = 0;
    int n_tests = 0, n_fail = 0;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask), .req_load_ctrl(req_load_ctrl), .stall(stall),
        .load_valid(load_valid), .load_data(load_data), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // waits = bus cycles without ack before the acking one; waits >= TO means the bus never answers.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input logic [2:0] ctrl, input logic [31:0] rdata, input int waits);
        int size, stall_n, req_n;
        logic exp_bad, exp_to, lv, mis, err, done;
        logic [31:0] word, exp_ld, ld;
        size = we ? $countones(mask) : (ctrl == 0 || ctrl == 3) ? 1 : (ctrl == 1 || ctrl == 4) ? 2 : 4;
        exp_bad = (addr % size) != 0;
        exp_to = waits >= TO;
        word = rdata >> (8 * addr[1:0]);
        case (ctrl)
            3'd0: exp_ld = 32'($signed(word[7:0]));
            3'd3: exp_ld = 32'(word[7:0]);
            3'd1: exp_ld = 32'($signed(word[15:0]));
            3'd4: exp_ld = 32'(word[15:0]);
            default: exp_ld = word;
        endcase
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_mask = mask; req_load_ctrl = ctrl;
        #1;
        check("stall_on_request", stall, 1);
        stall_n = 1; req_n = 0; lv = 0; mis = 0; err = 0; done = 0; ld = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(posedge clk); #1;
            bus_ack = 0; bus_rdata = $urandom;
            if (bus_req) begin
                req_n++;
                check("bus_addr", bus_addr, addr & ~32'h3);
                check("bus_be", bus_be, we ? mask : 4'hF);
                check("bus_we", bus_we, we);
                if (we) check("bus_wdata", bus_wdata, wdata);
                if (!exp_to && req_n == waits + 1) begin
                    bus_ack = 1; bus_rdata = rdata;
                end
            end
            #1;
            if (stall) stall_n++;
            if (load_valid) begin lv = 1; ld = load_data; end
            mis |= misalign;
            err |= bus_err;
            done = !stall;
        end
        req_valid = 0;
        check("txn_finished_in_budget", done, 1);
        check("misalign", mis, exp_bad);
        check("bus_err", err, !exp_bad && exp_to);
        check("bus_req_cycles", req_n, exp_bad ? 0 : exp_to ? TO : waits + 1);
        check("stall_cycles", stall_n, exp_bad ? 1 : exp_to ? TO + 1 : waits + 2);
        check("load_valid", lv, !exp_bad && !exp_to && !we);
        if (!exp_bad && !exp_to && !we) check("load_data", ld, exp_ld);
        @(posedge clk); #2;
        check("idle_after", {stall, bus_req, load_valid, misalign, bus_err}, 0);
    endtask

    initial begin
        logic [3:0] masks [7];
        logic [3:0] m;
        logic we;
        masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {stall, bus_req, bus_we, load_valid, misalign, bus_err}, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_bus_be", bus_be, 0);
        check("reset_load_data", load_data, 0);
        @(posedge clk); #1; rst_n = 1;
        // bus_ack while idle must not produce anything
        bus_ack = 1; bus_rdata = 32'h1234_5678;
        @(posedge clk); #1; bus_ack = 0;
        @(posedge clk); #1;
        check("idle_ack_ignored", {bus_req, load_valid, stall}, 0);

        run_txn(0, 32'h100, 0, 0, 3'b010, 32'hDEADBEEF, 2);
        run_txn(0, 32'h103, 0, 0, 3'b000, 32'h80FF_0000, 1);
        run_txn(0, 32'h103, 0, 0, 3'b011, 32'h80FF_0000, 0);
        run_txn(1, 32'h202, 32'hABCD_0000, 4'b1100, 3'b010, 32'h0, 0);
        run_txn(0, 32'h101, 0, 0, 3'b010, 32'h0, 0);
        run_txn(1, 32'h201, 32'h0000_1234, 4'b0011, 3'b001, 32'h0, 0);
        run_txn(0, 32'h300, 0, 0, 3'b010, 32'h0, TO);
        run_txn(0, 32'h304, 0, 0, 3'b010, 32'hCAFE_F00D, 3);
        run_txn(0, 32'h306, 0, 0, 3'b111, 32'h0, 0);
        run_txn(0, 32'h306, 0, 0, 3'b100, 32'h8001_0000, 1);

        // reset while the bus is busy
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_addr = 32'h400; req_load_ctrl = 3'b010;
        @(posedge clk); #2;
        check("rst_case_bus_req", bus_req, 1);
        #1; req_valid = 0; rst_n = 0;
        @(posedge clk); #1; rst_n = 1;
        #1;
        check("rst_mid_bus_req", bus_req, 0);
        check("rst_mid_stall", stall, 0);
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; bus_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("late_ack_no_load", {load_valid, bus_req}, 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            m = masks[$urandom_range(0, 6)];
            run_txn(we, 32'($urandom_range(0, 255)), $urandom, m, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, TO + 1));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
